// File: rtl/reg_cmd_ctrl_pkg.sv
// reg_cmd_ctrl_pkg
//   Shared constants for the register command controller:
//   - command bytes (write / read) and the error response byte
//   - FSM state encoding
package reg_cmd_ctrl_pkg;

  localparam logic [7:0] CMD_WR  = 8'hAA;
  localparam logic [7:0] CMD_RD  = 8'hBB;
  localparam logic [7:0] ERR_RSP = 8'hEE;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_WR_ADDR = 3'd1;
  localparam logic [2:0] ENC_WR_DATA = 3'd2;
  localparam logic [2:0] ENC_WR_EXEC = 3'd3;
  localparam logic [2:0] ENC_RD_ADDR = 3'd4;
  localparam logic [2:0] ENC_RD_EXEC = 3'd5;
  localparam logic [2:0] ENC_RD_WAIT = 3'd6;
  localparam logic [2:0] ENC_TX_SEND = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_WR_ADDR = ENC_WR_ADDR,
    ST_WR_DATA = ENC_WR_DATA,
    ST_WR_EXEC = ENC_WR_EXEC,
    ST_RD_ADDR = ENC_RD_ADDR,
    ST_RD_EXEC = ENC_RD_EXEC,
    ST_RD_WAIT = ENC_RD_WAIT,
    ST_TX_SEND = ENC_TX_SEND
  } state_t;

endpackage

// File: rtl/reg_cmd_timeout_cnt.sv
// reg_cmd_timeout_cnt
//   Clearable up-counter used to bound the wait for read data.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     i_clr     : clear count to zero (has priority over i_inc)
//     i_inc     : increment count by one
//     o_term    : high when the count is LIMIT-1, i.e. the increment taken
//                 this cycle brings the count to LIMIT
module reg_cmd_timeout_cnt #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_term
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_term = (r_cnt == W'(LIMIT - 1));

endmodule

// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl
//   Decodes UART byte frames into register-file strobes and returns read
//   data to the UART transmitter.
//     Write frame: AA, addr, data  -> one-cycle WrEn
//     Read frame : BB, addr        -> one-cycle RdEn, wait for RdData_Valid,
//                                     then send the byte via TX handshake
//   Ports:
//     CLK, RST            : clock, asynchronous active-high reset
//     RX_P_DATA, RX_D_VLD : received byte and its one-cycle strobe
//     RdData, RdData_Valid: register-file read return
//     TX_Busy             : transmitter busy, holds off TX_D_VLD
//     WrEn, RdEn          : register-file strobes (mutually exclusive)
//     Address, WrData     : latched frame fields, stable until next frame
//     TX_P_DATA, TX_D_VLD : byte to transmit and its one-cycle strobe
//   Handshake: RX_D_VLD and RdData_Valid are single-cycle strobes with no
//   back-pressure; a byte is consumed only in states that expect one and is
//   otherwise dropped. TX_D_VLD is raised only in a cycle with TX_Busy low.
//   Build option: REG_CMD_ERR_RSP_EN -- unknown command bytes and read
//   timeouts send ERR_RSP (8'hEE) instead of being silently dropped.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int RD_TIMEOUT    = 15
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     TX_Busy,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  state_t r_state;
  state_t w_next;

  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_tx_data;

  logic w_is_wr_cmd;
  logic w_is_rd_cmd;
  logic w_tmo_term;
  logic w_lat_addr;
  logic w_lat_data;
  logic w_rd_capture;
  logic w_tmo_expire;

  assign w_is_wr_cmd  = (RX_P_DATA == DATA_WIDTH'(CMD_WR));
  assign w_is_rd_cmd  = (RX_P_DATA == DATA_WIDTH'(CMD_RD));
  assign w_lat_addr   = RX_D_VLD && ((r_state == ST_WR_ADDR) || (r_state == ST_RD_ADDR));
  assign w_lat_data   = RX_D_VLD && (r_state == ST_WR_DATA);
  assign w_rd_capture = (r_state == ST_RD_WAIT) && RdData_Valid;
  // Valid data on the final wait cycle still wins over the timeout.
  assign w_tmo_expire = (r_state == ST_RD_WAIT) && !RdData_Valid && w_tmo_term;

  reg_cmd_timeout_cnt #(
    .LIMIT (RD_TIMEOUT)
  ) u_tmo (
    .clk    (CLK),
    .rst    (RST),
    .i_clr  (r_state == ST_RD_EXEC),
    .i_inc  ((r_state == ST_RD_WAIT) && !RdData_Valid),
    .o_term (w_tmo_term)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (w_is_wr_cmd) begin
            w_next = ST_WR_ADDR;
          end else if (w_is_rd_cmd) begin
            w_next = ST_RD_ADDR;
          end else begin
`ifdef REG_CMD_ERR_RSP_EN
            w_next = ST_TX_SEND;
`else
            w_next = ST_IDLE;
`endif
          end
        end
      end
      ST_WR_ADDR: if (RX_D_VLD) w_next = ST_WR_DATA;
      ST_WR_DATA: if (RX_D_VLD) w_next = ST_WR_EXEC;
      ST_WR_EXEC: w_next = ST_IDLE;
      ST_RD_ADDR: if (RX_D_VLD) w_next = ST_RD_EXEC;
      ST_RD_EXEC: w_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (w_rd_capture) begin
          w_next = ST_TX_SEND;
        end else if (w_tmo_expire) begin
`ifdef REG_CMD_ERR_RSP_EN
          w_next = ST_TX_SEND;
`else
          w_next = ST_IDLE;
`endif
        end
      end
      ST_TX_SEND: if (!TX_Busy) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_lat_addr) r_addr <= RX_P_DATA[ADDRESS_WIDTH-1:0];
      if (w_lat_data) r_wdata <= RX_P_DATA;
      if (w_rd_capture) begin
        r_tx_data <= RdData;
      end
`ifdef REG_CMD_ERR_RSP_EN
      else if (w_tmo_expire ||
               ((r_state == ST_IDLE) && RX_D_VLD && !w_is_wr_cmd && !w_is_rd_cmd)) begin
        r_tx_data <= DATA_WIDTH'(ERR_RSP);
      end
`endif
    end
  end

  always_comb begin
    WrEn     = 1'b0;
    RdEn     = 1'b0;
    TX_D_VLD = 1'b0;
    case (r_state)
      ST_WR_EXEC: WrEn     = 1'b1;
      ST_RD_EXEC: RdEn     = 1'b1;
      ST_TX_SEND: TX_D_VLD = !TX_Busy;
      default: ;
    endcase
  end

  assign Address   = r_addr;
  assign WrData    = r_wdata;
  assign TX_P_DATA = r_tx_data;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
module tb_reg_cmd_ctrl;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TMO = 15;
  localparam logic [7:0] B_WR  = 8'hAA;
  localparam logic [7:0] B_RD  = 8'hBB;
  localparam logic [7:0] B_ERR = 8'hEE;

  // Scoreboard event: {kind[1:0], addr[3:0], data[7:0]}; kind 1=write 2=read 3=tx
  localparam int EW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_p_data = '0;
  logic          rx_d_vld = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic          rd_data_valid = 1'b0;
  logic          tx_busy = 1'b0;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] tx_p_data;
  logic          tx_d_vld;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  reg_cmd_ctrl #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .RD_TIMEOUT    (TMO)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .RX_P_DATA    (rx_p_data),
    .RX_D_VLD     (rx_d_vld),
    .RdData       (rd_data),
    .RdData_Valid (rd_data_valid),
    .TX_Busy      (tx_busy),
    .WrEn         (wr_en),
    .RdEn         (rd_en),
    .Address      (address),
    .WrData       (wr_data),
    .TX_P_DATA    (tx_p_data),
    .TX_D_VLD     (tx_d_vld)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic mon_event(input logic [EW-1:0] ev);
    if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 32'(0));
    else check("event_order", 32'(ev), 32'(exp_q.pop_front()));
  endtask

  // Observe strobes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && rd_en) check("wr_rd_exclusive", 32'(1), 32'(0));
      if (tx_d_vld && tx_busy) check("tx_vld_while_busy", 32'(1), 32'(0));
      if (wr_en)    mon_event({2'd1, address, wr_data});
      if (rd_en)    mon_event({2'd2, address, 8'h00});
      if (tx_d_vld) mon_event({2'd3, 4'h0, tx_p_data});
    end
  end

  // ---------------- reference model ----------------
  function automatic void model_write(input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({2'd1, a[3:0], d});
  endfunction

  // lat = wait cycle (1 = cycle after RdEn) at which read data is offered.
  function automatic void model_read(input logic [7:0] a, input logic [7:0] d, input int lat);
    exp_q.push_back({2'd2, a[3:0], 8'h00});
    if (lat >= 1 && lat <= TMO) exp_q.push_back({2'd3, 4'h0, d});
`ifdef REG_CMD_ERR_RSP_EN
    else exp_q.push_back({2'd3, 4'h0, B_ERR});
`endif
  endfunction

  function automatic void model_unknown();
`ifdef REG_CMD_ERR_RSP_EN
    exp_q.push_back({2'd3, 4'h0, B_ERR});
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_p_data = b;
    rx_d_vld  = 1'b1;
    tick();
    rx_d_vld  = 1'b0;
    rx_p_data = 8'($urandom);
  endtask

  task automatic write_frame(input logic [7:0] a, input logic [7:0] d, input int gap);
    model_write(a, d);
    send_byte(B_WR);
    idle(gap);
    send_byte(a);
    idle(gap);
    send_byte(d);
    check("wr_latency", 32'(wr_en), 32'(1));
    tick();
    check("wr_one_cycle", 32'(wr_en), 32'(0));
    check("addr_hold", 32'(address), 32'(a[3:0]));
    check("wdata_hold", 32'(wr_data), 32'(d));
    idle(2);
  endtask

  task automatic read_frame(input logic [7:0] a, input logic [7:0] d, input int lat,
                            input int busy, input int gap);
    bit acc;
    acc = (lat >= 1 && lat <= TMO);
    model_read(a, d, lat);
    send_byte(B_RD);
    idle(gap);
    send_byte(a);
    check("rd_latency", 32'(rd_en), 32'(1));
    idle(lat);
    rd_data       = d;
    rd_data_valid = 1'b1;
    tx_busy       = (busy > 0);
    tick();
    rd_data_valid = 1'b0;
    rd_data       = 8'($urandom);
    for (int i = 1; i < busy; i++) begin
      if (acc) check("tx_hold_busy", 32'({tx_d_vld, tx_p_data}), 32'({1'b0, d}));
      tick();
    end
    tx_busy = 1'b0;
    #1;
    if (acc) check("tx_fire", 32'({tx_d_vld, tx_p_data}), 32'({1'b1, d}));
    idle(4);
  endtask

  task automatic unknown_byte(input logic [7:0] b);
    model_unknown();
    send_byte(b);
    idle(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check("rst_outputs", 32'({wr_en, rd_en, tx_d_vld, address, wr_data, tx_p_data}), 32'(0));
    tick();
    rst = 1'b0;
    idle(2);

    write_frame(8'h05, 8'h3C, 3);
    read_frame(8'h02, 8'h81, 1, 0, 0);
    read_frame(8'h03, 8'h5A, 1, 20, 1);
    read_frame(8'h07, 8'h11, 40, 0, 0);   // data never inside the window
    read_frame(8'h09, 8'h6D, TMO, 0, 0);  // last wait cycle: accepted
    read_frame(8'h0A, 8'h4E, TMO + 1, 2, 0);  // one cycle late: abandoned
    unknown_byte(8'h55);
    write_frame(8'h01, 8'hFF, 0);
    write_frame(8'hF3, 8'h77, 1);         // upper address bits dropped

    // Reset between address and data bytes of a write.
    send_byte(B_WR);
    send_byte(8'h05);
    idle(1);
    #2 rst = 1'b1;
    #1 check("rst_mid_frame", 32'({wr_en, rd_en, tx_d_vld, address, wr_data, tx_p_data}), 32'(0));
    tick();
    rst = 1'b0;
    idle(1);
    unknown_byte(8'h3C);                  // now taken as a command byte

    for (int n = 0; n < 60; n++) begin
      int kind;
      logic [7:0] a;
      logic [7:0] d;
      kind = $urandom_range(0, 5);
      a    = 8'($urandom);
      d    = 8'($urandom);
      if (kind <= 1) write_frame(a, d, $urandom_range(0, 3));
      else if (kind <= 4) read_frame(a, d, $urandom_range(1, TMO + 2), $urandom_range(0, 5),
                                      $urandom_range(0, 3));
      else begin
        logic [7:0] u;
        u = 8'($urandom);
        if (u == B_WR || u == B_RD) u = 8'h00;
        unknown_byte(u);
      end
    end

    idle(5);
    check("events_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
